// File: rtl/vga_sprite_renderer.sv
// 16x16 one-bit sprite overlay for a VGA pixel stream.
// Sprite position changes are taken via a ready/valid port and applied only at the vsync falling edge.
`timescale 1ns/1ps
module vga_sprite_renderer #(
    parameter logic [5:0] FG_COLOUR = 6'b111111,
    parameter logic [5:0] BG_COLOUR = 6'b000001,
    parameter logic [9:0] RESET_X   = 10'd320,
    parameter logic [9:0] RESET_Y   = 10'd240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       enable_pixel,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       pos_valid,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic       pos_ready,
    output logic [5:0] rgb,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic       frame_tick
);

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SPRITE_W = 16;
    localparam int unsigned IDX_W    = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [COORD_W-1:0] pending_x, pending_y, pending_x_next, pending_y_next;
    logic [COORD_W-1:0] active_x, active_y, active_x_next, active_y_next;
    logic               vsync_prev;
    logic               frame_boundary_c;

    assign frame_boundary_c = vsync_prev && !v_sync_in;

    // Position FSM: IDLE accepts an offer, PENDING waits for the next frame boundary.
    always_comb begin
        state_next     = state;
        pending_x_next = pending_x;
        pending_y_next = pending_y;
        active_x_next  = active_x;
        active_y_next  = active_y;
        case (state)
            IDLE: begin
                if (pos_valid) begin
                    state_next     = PENDING;
                    pending_x_next = pos_x;
                    pending_y_next = pos_y;
                end
            end
            PENDING: begin
                if (frame_boundary_c) begin
                    state_next    = IDLE;
                    active_x_next = pending_x;
                    active_y_next = pending_y;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending_x  <= '0;
            pending_y  <= '0;
            active_x   <= RESET_X;
            active_y   <= RESET_Y;
            vsync_prev <= 1'b1;
            frame_tick <= 1'b0;
            pos_ready  <= 1'b1;
        end else begin
            state      <= state_next;
            pending_x  <= pending_x_next;
            pending_y  <= pending_y_next;
            active_x   <= active_x_next;
            active_y   <= active_y_next;
            vsync_prev <= v_sync_in;
            frame_tick <= frame_boundary_c;
            pos_ready  <= (state_next == IDLE);
        end
    end

    // Stage 1: offset into the sprite, modulo 1024 so the sprite wraps at the edges.
    logic [COORD_W-1:0] dx_c, dy_c;
    logic               hit_c;
    logic [IDX_W-1:0]   s1_dx, s1_dy;
    logic               s1_hit, s1_en, s1_hsync, s1_vsync;

    assign dx_c  = COORD_W'(pixel_x - active_x);
    assign dy_c  = COORD_W'(pixel_y - active_y);
    assign hit_c = enable_pixel && (dx_c[COORD_W-1:IDX_W] == '0) && (dy_c[COORD_W-1:IDX_W] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_hit   <= 1'b0;
            s1_en    <= 1'b0;
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
        end else begin
            s1_dx    <= dx_c[IDX_W-1:0];
            s1_dy    <= dy_c[IDX_W-1:0];
            s1_hit   <= hit_c;
            s1_en    <= enable_pixel;
            s1_hsync <= h_sync_in;
            s1_vsync <= v_sync_in;
        end
    end

    // Sprite ROM: hollow square outline, bit 15 is the leftmost column.
    function automatic logic [SPRITE_W-1:0] sprite_row(input logic [IDX_W-1:0] row);
        return ((row == 4'd0) || (row == 4'd15)) ? 16'hFFFF : 16'h8001;
    endfunction

    logic [SPRITE_W-1:0] row_bits_c;
    logic                pixel_on_c;

    assign row_bits_c = sprite_row(s1_dy);
    assign pixel_on_c = s1_hit && row_bits_c[IDX_W'(4'd15 - s1_dx)];

    // Stage 2: colour select, syncs delayed alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb        <= '0;
            h_sync_out <= 1'b1;
            v_sync_out <= 1'b1;
        end else begin
            if (pixel_on_c)
                rgb <= FG_COLOUR;
            else if (s1_en)
                rgb <= BG_COLOUR;
            else
                rgb <= '0;
            h_sync_out <= s1_hsync;
            v_sync_out <= s1_vsync;
        end
    end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Directed bench for vga_sprite_renderer: pixel colours, position handshake, frame boundaries, wrap, sync delay, reset.
`timescale 1ns/1ps
module tb_vga_sprite_renderer;

    localparam logic [5:0] FG    = 6'b111111;
    localparam logic [5:0] BG    = 6'b000001;
    localparam logic [5:0] BLACK = 6'b000000;

    logic       clk = 1'b0;
    logic       reset;
    logic       h_sync_in, v_sync_in, enable_pixel;
    logic [9:0] pixel_x, pixel_y;
    logic       pos_valid;
    logic [9:0] pos_x, pos_y;
    logic       pos_ready;
    logic [5:0] rgb;
    logic       h_sync_out, v_sync_out, frame_tick;

    int passed = 0;
    int total  = 0;

    vga_sprite_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .h_sync_in    (h_sync_in),
        .v_sync_in    (v_sync_in),
        .enable_pixel (enable_pixel),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pos_valid    (pos_valid),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .pos_ready    (pos_ready),
        .rgb          (rgb),
        .h_sync_out   (h_sync_out),
        .v_sync_out   (v_sync_out),
        .frame_tick   (frame_tick)
    );

    always #20 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y, input logic en);
        pixel_x      = x;
        pixel_y      = y;
        enable_pixel = en;
        tick();
        tick();
    endtask

    task automatic offer(input logic [9:0] x, input logic [9:0] y);
        pos_valid = 1'b1;
        pos_x     = x;
        pos_y     = y;
        tick();
        pos_valid = 1'b0;
    endtask

    task automatic frame_edge(output logic ft, output logic pr);
        v_sync_in = 1'b0;
        tick();
        ft        = frame_tick;
        pr        = pos_ready;
        v_sync_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        h_sync_in    = 1'b1;
        v_sync_in    = 1'b1;
        enable_pixel = 1'b0;
        pixel_x      = '0;
        pixel_y      = '0;
        pos_valid    = 1'b0;
        pos_x        = '0;
        pos_y        = '0;
        #5;
        total++; if (pos_ready !== 1'b1) $display("FAIL reset_pos_ready: got %b want 1", pos_ready); else passed++;
        total++; if (rgb !== BLACK) $display("FAIL reset_rgb: got %h want %h", rgb, BLACK); else passed++;
        total++; if (h_sync_out !== 1'b1) $display("FAIL reset_hsync: got %b want 1", h_sync_out); else passed++;
        total++; if (v_sync_out !== 1'b1) $display("FAIL reset_vsync: got %b want 1", v_sync_out); else passed++;
        total++; if (frame_tick !== 1'b0) $display("FAIL reset_frame_tick: got %b want 0", frame_tick); else passed++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_pixels();
        drive_pixel(10'd320, 10'd240, 1'b1);
        total++; if (rgb !== FG) $display("FAIL pix_320_240: got %h want %h", rgb, FG); else passed++;
        drive_pixel(10'd321, 10'd241, 1'b1);
        total++; if (rgb !== BG) $display("FAIL pix_321_241: got %h want %h", rgb, BG); else passed++;
        drive_pixel(10'd336, 10'd240, 1'b1);
        total++; if (rgb !== BG) $display("FAIL pix_336_240: got %h want %h", rgb, BG); else passed++;
        drive_pixel(10'd335, 10'd241, 1'b1);
        total++; if (rgb !== FG) $display("FAIL pix_335_241: got %h want %h", rgb, FG); else passed++;
        drive_pixel(10'd320, 10'd240, 1'b0);
        total++; if (rgb !== BLACK) $display("FAIL pix_blank: got %h want %h", rgb, BLACK); else passed++;
    endtask

    task automatic test_position_update();
        logic ft, pr;
        offer(10'd100, 10'd50);
        total++; if (pos_ready !== 1'b0) $display("FAIL upd_ready_low: got %b want 0", pos_ready); else passed++;
        drive_pixel(10'd100, 10'd50, 1'b1);
        total++; if (rgb !== BG) $display("FAIL upd_before_edge: got %h want %h", rgb, BG); else passed++;
        drive_pixel(10'd320, 10'd240, 1'b1);
        total++; if (rgb !== FG) $display("FAIL upd_old_still: got %h want %h", rgb, FG); else passed++;
        frame_edge(ft, pr);
        total++; if (ft !== 1'b1) $display("FAIL upd_frame_tick: got %b want 1", ft); else passed++;
        total++; if (pr !== 1'b1) $display("FAIL upd_ready_back: got %b want 1", pr); else passed++;
        total++; if (frame_tick !== 1'b0) $display("FAIL upd_tick_one_cycle: got %b want 0", frame_tick); else passed++;
        drive_pixel(10'd100, 10'd50, 1'b1);
        total++; if (rgb !== FG) $display("FAIL upd_after_edge: got %h want %h", rgb, FG); else passed++;
        drive_pixel(10'd99, 10'd50, 1'b1);
        total++; if (rgb !== BG) $display("FAIL upd_left_of_sprite: got %h want %h", rgb, BG); else passed++;
    endtask

    task automatic test_pending_ignored();
        logic ft, pr;
        offer(10'd30, 10'd40);
        offer(10'd200, 10'd200);
        total++; if (pos_ready !== 1'b0) $display("FAIL pend_ready_low: got %b want 0", pos_ready); else passed++;
        frame_edge(ft, pr);
        total++; if (pr !== 1'b1) $display("FAIL pend_ready_back: got %b want 1", pr); else passed++;
        drive_pixel(10'd200, 10'd200, 1'b1);
        total++; if (rgb !== BG) $display("FAIL pend_ignored_pos: got %h want %h", rgb, BG); else passed++;
        drive_pixel(10'd30, 10'd40, 1'b1);
        total++; if (rgb !== FG) $display("FAIL pend_first_pos: got %h want %h", rgb, FG); else passed++;
        drive_pixel(10'd45, 10'd55, 1'b1);
        total++; if (rgb !== FG) $display("FAIL pend_bottom_right: got %h want %h", rgb, FG); else passed++;
    endtask

    task automatic test_accept_at_boundary();
        logic ft, pr;
        pos_valid = 1'b1;
        pos_x     = 10'd10;
        pos_y     = 10'd10;
        v_sync_in = 1'b0;
        tick();
        pos_valid = 1'b0;
        total++; if (frame_tick !== 1'b1) $display("FAIL coinc_frame_tick: got %b want 1", frame_tick); else passed++;
        total++; if (pos_ready !== 1'b0) $display("FAIL coinc_ready_low: got %b want 0", pos_ready); else passed++;
        v_sync_in = 1'b1;
        tick();
        drive_pixel(10'd10, 10'd10, 1'b1);
        total++; if (rgb !== BG) $display("FAIL coinc_not_applied: got %h want %h", rgb, BG); else passed++;
        drive_pixel(10'd30, 10'd40, 1'b1);
        total++; if (rgb !== FG) $display("FAIL coinc_old_kept: got %h want %h", rgb, FG); else passed++;
        frame_edge(ft, pr);
        total++; if (pr !== 1'b1) $display("FAIL coinc_ready_back: got %b want 1", pr); else passed++;
        drive_pixel(10'd10, 10'd10, 1'b1);
        total++; if (rgb !== FG) $display("FAIL coinc_applied: got %h want %h", rgb, FG); else passed++;
    endtask

    task automatic test_wrap();
        logic ft, pr;
        offer(10'd1020, 10'd0);
        frame_edge(ft, pr);
        drive_pixel(10'd2, 10'd0, 1'b1);
        total++; if (rgb !== FG) $display("FAIL wrap_2_0: got %h want %h", rgb, FG); else passed++;
        drive_pixel(10'd12, 10'd0, 1'b1);
        total++; if (rgb !== BG) $display("FAIL wrap_12_0: got %h want %h", rgb, BG); else passed++;
        drive_pixel(10'd1023, 10'd5, 1'b1);
        total++; if (rgb !== BG) $display("FAIL wrap_1023_5: got %h want %h", rgb, BG); else passed++;
        drive_pixel(10'd1020, 10'd5, 1'b1);
        total++; if (rgb !== FG) $display("FAIL wrap_1020_5: got %h want %h", rgb, FG); else passed++;
        drive_pixel(10'd11, 10'd15, 1'b1);
        total++; if (rgb !== FG) $display("FAIL wrap_11_15: got %h want %h", rgb, FG); else passed++;
    endtask

    task automatic test_sync_pipeline();
        logic [7:0] h_pat;
        logic [7:0] v_pat;
        h_pat        = 8'b1010_0110;
        v_pat        = 8'b1100_1010;
        enable_pixel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            h_sync_in = h_pat[i];
            v_sync_in = v_pat[i];
            tick();
            if (i >= 1) begin
                total++; if (h_sync_out !== h_pat[i-1]) $display("FAIL sync_h_%0d: got %b want %b", i, h_sync_out, h_pat[i-1]); else passed++;
                total++; if (v_sync_out !== v_pat[i-1]) $display("FAIL sync_v_%0d: got %b want %b", i, v_sync_out, v_pat[i-1]); else passed++;
                total++; if (rgb !== BLACK) $display("FAIL sync_rgb_%0d: got %h want %h", i, rgb, BLACK); else passed++;
            end
        end
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        logic ft, pr;
        h_sync_in = 1'b0;
        offer(10'd500, 10'd500);
        tick();
        total++; if (pos_ready !== 1'b0) $display("FAIL arst_pending: got %b want 0", pos_ready); else passed++;
        total++; if (h_sync_out !== 1'b0) $display("FAIL arst_hsync_pre: got %b want 0", h_sync_out); else passed++;
        #5;
        reset = 1'b1;
        #1;
        total++; if (pos_ready !== 1'b1) $display("FAIL arst_pos_ready: got %b want 1", pos_ready); else passed++;
        total++; if (h_sync_out !== 1'b1) $display("FAIL arst_hsync: got %b want 1", h_sync_out); else passed++;
        total++; if (rgb !== BLACK) $display("FAIL arst_rgb: got %h want %h", rgb, BLACK); else passed++;
        h_sync_in = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        frame_edge(ft, pr);
        total++; if (ft !== 1'b1) $display("FAIL arst_frame_tick: got %b want 1", ft); else passed++;
        drive_pixel(10'd320, 10'd240, 1'b1);
        total++; if (rgb !== FG) $display("FAIL arst_home_pos: got %h want %h", rgb, FG); else passed++;
        drive_pixel(10'd500, 10'd500, 1'b1);
        total++; if (rgb !== BG) $display("FAIL arst_discarded: got %h want %h", rgb, BG); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_pixels();
        test_position_update();
        test_pending_ignored();
        test_accept_at_boundary();
        test_wrap();
        test_sync_pipeline();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_sprite_renderer.md
VGA_SPRITE_RENDERER -- requirements
Module: vga_sprite_renderer

Interface
REQ-001 Parameter FG_COLOUR, default 6'b111111, colour of a set sprite pixel as {R1,R0,G1,G0,B1,B0}.
REQ-002 Parameter BG_COLOUR, default 6'b000001, colour of an active-video pixel not covered by a set sprite bit.
REQ-003 Parameter RESET_X, default 10'd320, sprite x after reset.
REQ-004 Parameter RESET_Y, default 10'd240, sprite y after reset.
REQ-005 clk  in  1  25 MHz pixel clock; the only clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 h_sync_in  in  1  registered hsync from the VGA sync unit, active low.
REQ-008 v_sync_in  in  1  registered vsync from the VGA sync unit, active low.
REQ-009 enable_pixel  in  1  high while the current pixel is in active video.
REQ-010 pixel_x  in  10  current pixel x, same coordinate space as sprite position.
REQ-011 pixel_y  in  10  current pixel y, same coordinate space as sprite position.
REQ-012 pos_valid  in  1  new sprite position offered.
REQ-013 pos_x  in  10  offered sprite x, top-left corner.
REQ-014 pos_y  in  10  offered sprite y, top-left corner.
REQ-015 pos_ready  out  1  block can accept a position this cycle.
REQ-016 rgb  out  6  pixel colour.
REQ-017 h_sync_out  out  1  h_sync_in delayed to align with rgb.
REQ-018 v_sync_out  out  1  v_sync_in delayed to align with rgb.
REQ-019 frame_tick  out  1  one-cycle pulse when a new frame's position is applied.

Function
REQ-020 Sprite SHALL be 16x16, 1 bit per pixel, from an internal constant ROM: rows 0 and 15 = 16'hFFFF, rows 1-14 = 16'h8001; bit 15 = leftmost column.
REQ-021 Position update SHALL use a two-state FSM: IDLE (pos_ready=1) and PENDING (pos_ready=0).
REQ-022 In IDLE, pos_valid=1 SHALL load pending_x/pending_y from pos_x/pos_y and move to PENDING on that edge.
REQ-023 In PENDING, pos_valid SHALL be ignored; offered values are not captured.
REQ-024 Frame boundary SHALL be the cycle in which registered previous v_sync_in=1 and current v_sync_in=0 (falling edge).
REQ-025 At a frame boundary in PENDING: active_x/active_y <= pending values, FSM -> IDLE, frame_tick=1 for the following cycle only.
REQ-026 At a frame boundary in IDLE: active position unchanged, frame_tick still pulses once.
REQ-027 Acceptance in IDLE coinciding with a frame boundary SHALL go to PENDING only; it is applied at the next boundary.
REQ-028 Stage 1 (registered): dx = pixel_x - active_x, dy = pixel_y - active_y, both modulo 1024; hit = enable_pixel && dx<16 && dy<16; carry dx[3:0], dy[3:0], enable_pixel, syncs.
REQ-029 Modulo arithmetic SHALL allow horizontal and vertical wrap (e.g. active_x=1020 hits pixel_x 1020..1023 and 0..11).
REQ-030 Stage 2 (registered): rgb = FG_COLOUR if hit and ROM[dy][15-dx] = 1; BG_COLOUR if enable_pixel set and not; 6'b000000 if enable_pixel clear.
REQ-031 Latency from pixel_x/pixel_y/enable_pixel/syncs to rgb/h_sync_out/v_sync_out SHALL be exactly 2 cycles, identical for all four.
REQ-032 Active position SHALL only change at frame boundaries; never mid-frame.

Reset
REQ-033 On reset: FSM=IDLE, pos_ready=1, active=(RESET_X,RESET_Y), pending=0, rgb=0, h_sync_out=1, v_sync_out=1, frame_tick=0, previous-vsync register=1, all pipeline valid/hit bits=0.
REQ-034 Reset asserted mid-frame or in PENDING SHALL discard the pending position immediately, without waiting for a clock edge.

Verification
REQ-035 Reset, then pixel (320,240) enable=1 -> rgb=FG_COLOUR 2 cycles later; (321,241) -> BG_COLOUR; (336,240) -> BG_COLOUR.
REQ-036 pos_valid with (100,50) in IDLE -> pos_ready=0 next cycle; rgb unchanged at (100,50) until vsync falling edge; then frame_tick=1 one cycle, pos_ready=1, (100,50) -> FG_COLOUR.
REQ-037 In PENDING offer (200,200) -> not captured; after boundary active is the earlier pending value, not (200,200).
REQ-038 Accept (10,10) in the same cycle as vsync falling edge -> active unchanged this frame, frame_tick=1, pos_ready=0; applied at the following boundary.
REQ-039 active_x=1020, active_y=0: pixel (2,0) enable=1 -> FG_COLOUR (top row, column 6); pixel (12,0) -> BG_COLOUR.
REQ-040 Toggle h_sync_in/v_sync_in with enable_pixel=0 -> outputs follow exactly 2 cycles later, rgb=0 throughout; assert reset in PENDING -> pos_ready=1 with no clock edge.
